// File: rtl/sha3_pad_sequencer.sv
// Host-side sequencer for sha3_controller: feeds message bytes, appends pad10*1
// padding with the domain byte, and strobes start/valid/last_block one byte per two cycles.
module sha3_pad_sequencer #(
  parameter int          RATE_BYTES = 136,
  parameter logic [7:0]  DS_BYTE    = 8'h06
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_start,
  input  logic       msg_empty,
  input  logic       msg_valid,
  input  logic [7:0] msg_data,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic       core_start,
  output logic       core_valid,
  output logic [7:0] core_data,
  output logic       core_last_block,
  input  logic       core_absorb_rdy,
  input  logic       core_result_rdy,
  output logic       seq_busy,
  output logic       seq_done
);

  localparam int              PW       = $clog2(RATE_BYTES);
  localparam logic [PW-1:0]   LAST_POS = PW'(RATE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_PAD, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          first_pad_q, first_pad_d;
  logic          core_start_q, core_start_d;
  logic          core_valid_q, core_valid_d;
  logic [7:0]    core_data_q, core_data_d;
  logic          core_last_q, core_last_d;
  logic          seq_done_q, seq_done_d;
  logic          can_issue;
  logic          at_end;

  function automatic logic [7:0] pad_byte(input logic first, input logic last_pos);
    logic [7:0] b;
    b = first ? DS_BYTE : 8'h00;
    if (last_pos) b = b | 8'h80;
    return b;
  endfunction

  function automatic logic [PW-1:0] next_pos(input logic [PW-1:0] p);
    return (p == LAST_POS) ? '0 : p + 1'b1;
  endfunction

  // A byte may only follow an idle strobe cycle so the controller can drop absorb_ready.
  assign can_issue = core_absorb_rdy & ~core_valid_q;
  assign at_end    = (pos_q == LAST_POS);
  assign msg_ready = (state_q == S_FEED) & can_issue;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    first_pad_d  = first_pad_q;
    core_start_d = 1'b0;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    core_last_d  = 1'b0;
    seq_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msg_start) begin
          core_start_d = 1'b1;
          pos_d        = '0;
          if (msg_empty) begin
            state_d     = S_PAD;
            first_pad_d = 1'b1;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (msg_valid && msg_ready) begin
          core_valid_d = 1'b1;
          core_data_d  = msg_data;
          pos_d        = next_pos(pos_q);
          if (msg_last) begin
            state_d     = S_PAD;
            first_pad_d = 1'b1;
          end
        end
      end
      S_PAD: begin
        if (can_issue) begin
          core_valid_d = 1'b1;
          core_data_d  = pad_byte(first_pad_q, at_end);
          core_last_d  = at_end;
          pos_d        = next_pos(pos_q);
          first_pad_d  = 1'b0;
          if (at_end) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_result_rdy) begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs; reset clears every output so an aborted message emits nothing more.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pos_q        <= '0;
      first_pad_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_valid_q <= 1'b0;
      core_data_q  <= 8'h00;
      core_last_q  <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      first_pad_q  <= first_pad_d;
      core_start_q <= core_start_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      core_last_q  <= core_last_d;
      seq_done_q   <= seq_done_d;
    end
  end

  assign core_start      = core_start_q;
  assign core_valid      = core_valid_q;
  assign core_data       = core_data_q;
  assign core_last_block = core_last_q;
  assign seq_done        = seq_done_q;
  assign seq_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha3_pad_sequencer.sv
// Scoreboard bench for sha3_pad_sequencer: a padding model fills the expected byte
// queue per message and a monitor pops it on every core strobe.
module tb_sha3_pad_sequencer;
  localparam int         R  = 136;
  localparam logic [7:0] DS = 8'h06;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_start = 1'b0, msg_empty = 1'b0, msg_valid = 1'b0, msg_last = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_ready;
  logic       core_start, core_valid, core_last_block, seq_busy, seq_done;
  logic [7:0] core_data;
  logic       core_absorb_rdy = 1'b1, core_result_rdy = 1'b0;

  int         checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] msg_buf[$];
  int         start_pending = 0, done_pending = 0, bytes_seen = 0, stall_cycles = 0;
  bit         abs_rand = 1'b0;

  sha3_pad_sequencer #(.RATE_BYTES(R), .DS_BYTE(DS)) dut (
    .clk(clk), .rst(rst),
    .msg_start(msg_start), .msg_empty(msg_empty), .msg_valid(msg_valid),
    .msg_data(msg_data), .msg_last(msg_last), .msg_ready(msg_ready),
    .core_start(core_start), .core_valid(core_valid), .core_data(core_data),
    .core_last_block(core_last_block), .core_absorb_rdy(core_absorb_rdy),
    .core_result_rdy(core_result_rdy), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: message bytes, then pad10*1 up to the next multiple of R; last flag on final byte.
  task automatic build_expected();
    int n, padlen;
    logic [7:0] b;
    n = msg_buf.size();
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, msg_buf[i]});
    padlen = R - (n % R);
    for (int j = 0; j < padlen; j++) begin
      b = 8'h00;
      if (j == 0) b = b | DS;
      if (j == padlen - 1) b = b | 8'h80;
      exp_q.push_back({(j == padlen - 1), b});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    start_pending = 0;
    done_pending  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {core_start, core_valid, core_data, core_last_block, seq_busy, seq_done, msg_ready}, 0);
  endtask

  task automatic send_msg(input bit gaps, input bit start_in_feed, input bit stall, input int rst_after);
    int k, base, n;
    n = msg_buf.size();
    build_expected();
    start_pending++;
    done_pending++;
    base = bytes_seen;
    @(posedge clk); #1;
    msg_start = 1'b1;
    msg_empty = (n == 0);
    msg_valid = 1'($urandom_range(0, 1));
    msg_data  = 8'hEE;
    msg_last  = 1'b1;
    @(posedge clk); #1;
    chk("start_lat", core_start, 1);
    msg_start = 1'b0; msg_empty = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      msg_valid = 1'b1;
      msg_data  = msg_buf[i];
      msg_last  = (i == n - 1);
      if (start_in_feed && i == n / 2) msg_start = 1'b1;
      k = 0;
      @(negedge clk);
      while (!msg_ready && k < 500) begin @(negedge clk); k++; end
      if (!msg_ready) begin
        chk("handshake_timeout", msg_ready, 1);
        msg_valid = 1'b0; msg_last = 1'b0; msg_start = 1'b0;
        return;
      end
      if (stall && i == n - 1) stall_cycles = 30;
      @(posedge clk); #1;
      chk("byte_lat", {core_valid, core_data}, {1'b1, msg_buf[i]});
      msg_start = 1'b0;
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    if (stall) begin
      @(negedge clk);
      for (int s = 1; s < 30; s++) begin
        @(negedge clk);
        chk("stall_quiet", {core_valid, msg_ready}, 0);
      end
    end
    if (rst_after > 0) begin
      k = 0;
      while ((bytes_seen - base) < rst_after && k < 2000) begin @(negedge clk); k++; end
      chk("reached_pad", ((bytes_seen - base) >= rst_after), 1);
      do_reset();
      return;
    end
    k = 0;
    while (done_pending > 0 && k < 5000) begin @(negedge clk); k++; end
    chk("done_seen", done_pending, 0);
    chk("stream_drained", exp_q.size(), 0);
  endtask

  // Controller stand-in: absorb_ready (random or stalled) and result_ready after last block.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cycles > 0) begin
        core_absorb_rdy = 1'b0;
        stall_cycles--;
      end else begin
        core_absorb_rdy = abs_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && core_valid && core_last_block) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 core_result_rdy = 1'b1;
        for (int k = 0; k < 20 && seq_busy; k++) @(negedge clk);
        @(posedge clk); #1 core_result_rdy = 1'b0;
      end
    end
  end

  // Monitor
  initial begin : monitor
    logic [8:0] e;
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (core_valid) begin
          chk("rate_gap", prev_v, 0);
          bytes_seen++;
          chk("byte_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("core_byte", {core_last_block, core_data}, e);
          end
        end else begin
          chk("last_without_valid", core_last_block, 0);
        end
        if (core_start) begin
          chk("start_expected", (start_pending > 0), 1);
          if (start_pending > 0) start_pending--;
        end
        if (seq_done) begin
          chk("done_expected", (done_pending > 0), 1);
          chk("done_stream_complete", exp_q.size(), 0);
          if (done_pending > 0) done_pending--;
        end
        prev_v = core_valid;
      end
    end
  end

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {core_start, core_valid, core_data, core_last_block, seq_busy, seq_done, msg_ready}, 0);

    msg_buf.delete();
    send_msg(0, 0, 0, 0);

    msg_buf = '{8'h61, 8'h62, 8'h63};
    send_msg(0, 0, 0, 0);

    abs_rand = 1'b1;
    msg_buf.delete();
    for (int i = 0; i < R - 1; i++) msg_buf.push_back(8'($urandom));
    send_msg(1, 0, 0, 0);

    abs_rand = 1'b0;
    msg_buf.delete();
    for (int i = 0; i < R; i++) msg_buf.push_back(8'($urandom));
    send_msg(0, 0, 1, 0);

    msg_buf.delete();
    for (int i = 0; i < 200; i++) msg_buf.push_back(8'($urandom));
    send_msg(0, 1, 0, 0);

    abs_rand = 1'b1;
    msg_buf = '{8'h61, 8'h62, 8'h63};
    send_msg(1, 0, 0, 13);
    msg_buf = '{8'h61, 8'h62, 8'h63};
    send_msg(0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      len = (t == 0) ? 2 * R : int'($urandom_range(0, 300));
      msg_buf.delete();
      for (int i = 0; i < len; i++) msg_buf.push_back(8'($urandom));
      send_msg(1, 0, 0, 0);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
